safe_cpu_wrapper_csr: RTL and testbench

//  Register-interface CSR block for the safe CPU wrapper, sitting downstream of the reg_mux that merges the

---
 rtl/safe_cpu_wrapper_csr.sv | 228 ++++++++++++++++++++++
 tb/tb_safe_cpu_wrapper_csr.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/safe_cpu_wrapper_csr.sv
// safe_cpu_wrapper_csr
//   CSR block for the safe CPU wrapper. It holds the pending and active redundancy
//   mode and master hart. It runs a halt -> apply -> resume sequence, so that a
//   mode change only takes effect while every hart is quiesced.
//
//   Ports
//     clk_i, rst_i    clock, asynchronous active-high reset
//     reg_req_i       register request (valid/write/addr/wdata/wstrb)
//     reg_rsp_o       register response (ready/rdata/error), zero wait state
//     halt_req_o      per-hart halt request
//     halt_ack_i      per-hart halted acknowledge
//     mode_o          active mode: 0 single, 1 dual lockstep, 2 triple lockstep
//     master_core_o   active master hart index
//     busy_o          sequencer not idle
//     irq_o           switch-done pulse
//
//   Optional feature macro: SAFE_CSR_IRQ_EN. It enables irq_o and STATUS[31]
//   irq_pending, which is cleared by writing 1 to it (W1C). Without the macro,
//   irq_o is tied low and any STATUS write returns an error.
//
//   Register map (decoded by addr[3:2] only)
//     0x0 CTRL    [1:0] pend_mode RW, [2] START (write-only, reads 0)
//     0x4 STATUS  [1:0] mode, [2] busy, [3] timeout_err, [4+:NHARTS] halt_ack, [31] irq_pending
//     0x8 MASTER  [1:0] pend_master RW
//     0xC TIMEOUT [15:0] halt acknowledge budget in cycles
//
//   state  | meaning
//   IDLE   | no switch in progress
//   HALT   | halt requested, waiting for all acks or timeout
//   APPLY  | one cycle, pending mode/master copied to active outputs
//   RESUME | halt released, waiting for every ack to drop

package safe_cpu_wrapper_csr_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;
endpackage

module safe_cpu_wrapper_csr
  import safe_cpu_wrapper_csr_pkg::*;
#(
  parameter int NHARTS      = 3,
  parameter int TIMEOUT_RST = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  reg_req_t          reg_req_i,
  output reg_rsp_t          reg_rsp_o,
  output logic [NHARTS-1:0] halt_req_o,
  input  logic [NHARTS-1:0] halt_ack_i,
  output logic [1:0]        mode_o,
  output logic [1:0]        master_core_o,
  output logic              busy_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_HALT, S_APPLY, S_RESUME} state_t;

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_MASTER  = 2'd2;
  localparam logic [1:0] A_TIMEOUT = 2'd3;
  localparam logic [2:0] NHARTS_W  = 3'(NHARTS);

  state_t      state;
  logic [1:0]  pend_mode;
  logic [1:0]  pend_master;
  logic [15:0] timeout_q;
  logic [15:0] cnt;
  logic        timeout_err;
  logic        irq_pending;

  logic        wr_en;
  logic        rd_en;
  logic [1:0]  sel;
  logic [1:0]  mode_nxt;
  logic [1:0]  master_nxt;
  logic [15:0] timeout_nxt;
  logic        start_bit;
  logic        wr_err;
  logic        ctrl_wr;
  logic        master_wr;
  logic        timeout_wr;
  logic [31:0] status_val;
  logic [31:0] rdata;

  // Request bits outside the decoded fields are intentionally ignored.
  logic unused_req_bits;
  assign unused_req_bits = ^{reg_req_i.addr[31:4], reg_req_i.addr[1:0], reg_req_i.wdata};

  assign busy_o = (state != S_IDLE);

  always_comb begin
    sel         = reg_req_i.addr[3:2];
    wr_en       = reg_req_i.valid & reg_req_i.write & (|reg_req_i.wstrb);
    rd_en       = reg_req_i.valid & ~reg_req_i.write;
    // Field values after applying byte strobes to the current contents.
    mode_nxt    = reg_req_i.wstrb[0] ? reg_req_i.wdata[1:0] : pend_mode;
    master_nxt  = reg_req_i.wstrb[0] ? reg_req_i.wdata[1:0] : pend_master;
    start_bit   = reg_req_i.wstrb[0] & reg_req_i.wdata[2];
    timeout_nxt[7:0]  = reg_req_i.wstrb[0] ? reg_req_i.wdata[7:0]  : timeout_q[7:0];
    timeout_nxt[15:8] = reg_req_i.wstrb[1] ? reg_req_i.wdata[15:8] : timeout_q[15:8];

    wr_err = 1'b0;
    if (wr_en) begin
      case (sel)
        A_CTRL:   wr_err = busy_o || (mode_nxt == 2'd3);
`ifdef SAFE_CSR_IRQ_EN
        A_STATUS: wr_err = 1'b0;
`else
        A_STATUS: wr_err = 1'b1;
`endif
        A_MASTER: wr_err = ({1'b0, master_nxt} >= NHARTS_W);
        default:  wr_err = 1'b0;
      endcase
    end

    ctrl_wr    = wr_en && (sel == A_CTRL)    && !wr_err;
    master_wr  = wr_en && (sel == A_MASTER)  && !wr_err;
    timeout_wr = wr_en && (sel == A_TIMEOUT);

    status_val              = '0;
    status_val[1:0]         = mode_o;
    status_val[2]           = busy_o;
    status_val[3]           = timeout_err;
    status_val[4 +: NHARTS] = halt_ack_i;
    status_val[31]          = irq_pending;

    rdata = '0;
    if (rd_en) begin
      case (sel)
        A_CTRL:   rdata = {30'd0, pend_mode};
        A_STATUS: rdata = status_val;
        A_MASTER: rdata = {30'd0, pend_master};
        default:  rdata = {16'd0, timeout_q};
      endcase
    end
  end

  assign reg_rsp_o.ready = reg_req_i.valid;
  assign reg_rsp_o.rdata = rdata;
  assign reg_rsp_o.error = wr_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      pend_mode     <= 2'd0;
      pend_master   <= 2'd0;
      timeout_q     <= 16'(TIMEOUT_RST);
      cnt           <= 16'd0;
      timeout_err   <= 1'b0;
      halt_req_o    <= '0;
      mode_o        <= 2'd0;
      master_core_o <= 2'd0;
    end else begin
      if (ctrl_wr)    pend_mode   <= mode_nxt;
      if (master_wr)  pend_master <= master_nxt;
      if (timeout_wr) timeout_q   <= timeout_nxt;

      case (state)
        S_IDLE: begin
          // ctrl_wr can only be set here, because CTRL writes error while busy.
          if (ctrl_wr && start_bit) begin
            state       <= S_HALT;
            halt_req_o  <= '1;
            cnt         <= timeout_q;
            timeout_err <= 1'b0;
          end
        end
        S_HALT: begin
          // All acks take priority over a coincident expiry.
          if (&halt_ack_i) begin
            state <= S_APPLY;
          end else if (cnt == 16'd0) begin
            state       <= S_IDLE;
            halt_req_o  <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_APPLY: begin
          mode_o        <= pend_mode;
          master_core_o <= pend_master;
          halt_req_o    <= '0;
          state         <= S_RESUME;
        end
        S_RESUME: begin
          if (~|halt_ack_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SAFE_CSR_IRQ_EN
  logic done;
  assign done = (state == S_RESUME) && ~|halt_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_o <= done;
      // A completing switch wins over a simultaneous clear.
      if (done)
        irq_pending <= 1'b1;
      else if (wr_en && (sel == A_STATUS) && reg_req_i.wstrb[3] && reg_req_i.wdata[31])
        irq_pending <= 1'b0;
    end
  end
`else
  assign irq_o       = 1'b0;
  assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_safe_cpu_wrapper_csr.sv
module tb_safe_cpu_wrapper_csr;
  import safe_cpu_wrapper_csr_pkg::*;

  localparam int NH = 3;
`ifdef SAFE_CSR_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  localparam logic [31:0] IRQB = {IRQ, 31'd0};

  logic          clk;
  logic          rst;
  reg_req_t      req;
  reg_rsp_t      rsp;
  logic [NH-1:0] halt_req;
  logic [NH-1:0] ack;
  logic [1:0]    mode;
  logic [1:0]    master;
  logic          busy;
  logic          irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  safe_cpu_wrapper_csr #(.NHARTS(NH), .TIMEOUT_RST(1024)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_req_i    (req),
    .reg_rsp_o    (rsp),
    .halt_req_o   (halt_req),
    .halt_ack_i   (ack),
    .mode_o       (mode),
    .master_core_o(master),
    .busy_o       (busy),
    .irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every presented request cycle pops one expectation.
  always @(negedge clk) begin
    if (req.valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL reg_unexpected addr=%h: no expectation queued", req.addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!rsp.ready || rsp.rdata !== e.rdata || rsp.error !== e.err) begin
          miscompares++;
          $display("FAIL reg addr=%h: got ready=%b rdata=%h error=%b, want ready=1 rdata=%h error=%b",
                   e.addr, rsp.ready, rsp.rdata, rsp.error, e.rdata, e.err);
        end
      end
    end
  end

  task automatic reg_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    e.addr = addr; e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    req.valid = 1'b1; req.write = wr; req.addr = addr; req.wdata = wdata; req.wstrb = wstrb;
    @(posedge clk); #1;
    req.valid = 1'b0; req.write = 1'b0; req.wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic exp_err);
    reg_op(1'b1, addr, data, strb, 32'h0, exp_err);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rdata);
    reg_op(1'b0, addr, 32'h0, 4'h0, exp_rdata, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; ack = '0;
    req = '0;
    cyc(3);
    check("rst_halt_req", 32'(halt_req), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    cyc(1);

    // Reset register contents
    rd(32'h4, 32'h0);
    rd(32'hC, 32'h400);
    rd(32'h0, 32'h0);
    rd(32'h8, 32'h0);

    // Illegal writes
    wr(32'h0, 32'h3, 4'h1, 1'b1);
    rd(32'h0, 32'h0);
    wr(32'h8, 32'h3, 4'h1, 1'b1);
    wr(32'h8, 32'h2, 4'h1, 1'b0);
    rd(32'h8, 32'h2);
    wr(32'h4, 32'h0, 4'h0, 1'b0);
    wr(32'h4, 32'h0, 4'hF, !IRQ);

    // Full switch to triple lockstep, acks arrive late
    wr(32'h0, 32'h6, 4'h1, 1'b0);
    check("sw_busy_halt", 32'(busy), 1);
    check("sw_halt_req", 32'(halt_req), 32'h7);
    wr(32'h0, 32'h1, 4'h1, 1'b1);
    rd(32'h10, 32'h2);
    rd(32'h4, 32'h4);
    cyc(2);
    check("sw_halt_hold", 32'(halt_req), 32'h7);
    ack = 3'b111;
    cyc(1);
    check("sw_apply_mode_old", 32'(mode), 0);
    check("sw_apply_halt_req", 32'(halt_req), 32'h7);
    cyc(1);
    check("sw_mode_new", 32'(mode), 2);
    check("sw_master_new", 32'(master), 2);
    check("sw_resume_halt_req", 32'(halt_req), 0);
    check("sw_resume_busy", 32'(busy), 1);
    cyc(1);
    check("sw_resume_wait", 32'(busy), 1);
    ack = '0;
    cyc(1);
    check("sw_idle_busy", 32'(busy), 0);
    check("sw_irq_pulse", 32'(irq), 32'(IRQ));
    cyc(1);
    check("sw_irq_end", 32'(irq), 0);
    rd(32'h4, 32'h2 | IRQB);
    wr(32'h4, 32'h8000_0000, 4'h8, !IRQ);
    rd(32'h4, 32'h2);

    // Timeout with 8-cycle budget, acks never arrive
    wr(32'hC, 32'h8, 4'h3, 1'b0);
    rd(32'hC, 32'h8);
    wr(32'h0, 32'h5, 4'h1, 1'b0);
    n = 0;
    while (busy && n < 50) begin cyc(1); n++; end
    check("to_cycles_in_range", 32'(n >= 8 && n <= 9), 1);
    check("to_mode_kept", 32'(mode), 2);
    check("to_halt_req", 32'(halt_req), 0);
    rd(32'h4, 32'hA);

    // Zero budget: expires on first HALT cycle unless acks already high
    wr(32'hC, 32'h0, 4'h3, 1'b0);
    rd(32'hC, 32'h0);
    wr(32'h0, 32'h5, 4'h1, 1'b0);
    check("to0_busy", 32'(busy), 1);
    cyc(1);
    check("to0_idle", 32'(busy), 0);
    rd(32'h4, 32'hA);
    ack = 3'b111;
    wr(32'h0, 32'h5, 4'h1, 1'b0);
    cyc(1);
    check("to0_ack_apply", 32'(busy), 1);
    cyc(1);
    check("to0_ack_mode", 32'(mode), 1);
    ack = '0;
    cyc(1);
    check("to0_ack_idle", 32'(busy), 0);
    rd(32'h4, 32'h1 | IRQB);

    // Byte strobes
    wr(32'hC, 32'h0000_1234, 4'h2, 1'b0);
    rd(32'hC, 32'h1200);

    // Reset in the middle of HALT
    wr(32'hC, 32'd100, 4'h3, 1'b0);
    wr(32'h8, 32'h1, 4'h1, 1'b0);
    ack = 3'b010;
    wr(32'h0, 32'h6, 4'h1, 1'b0);
    cyc(1);
    check("mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_halt_req", 32'(halt_req), 0);
    check("mid_rst_mode", 32'(mode), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_master", 32'(master), 0);
    rd(32'h4, 32'h20);
    rst = 1'b0;
    cyc(1);
    rd(32'hC, 32'h400);
    rd(32'h0, 32'h0);
    rd(32'h8, 32'h0);

    cyc(3);
    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
